// File: rtl/mure_pkg.sv
// Shared core types: functional-unit ops, E-Trace itype codes and link-register helpers.
package mure_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, ANDL, ORL, XORL, SLL, SRL, SRA, LD, SD,
    EQ, NE, LTS, GES, LTU, GEU,
    JAL, JALR, MRET, SRET, DRET, FENCE
  } fu_op;

  localparam logic [3:0] ITYPE_NONE             = 4'd0;
  localparam logic [3:0] ITYPE_EXCEPTION        = 4'd1;
  localparam logic [3:0] ITYPE_INTERRUPT        = 4'd2;
  localparam logic [3:0] ITYPE_ERET             = 4'd3;
  localparam logic [3:0] ITYPE_NONTAKEN_BRANCH  = 4'd4;
  localparam logic [3:0] ITYPE_TAKEN_BRANCH     = 4'd5;
  localparam logic [3:0] ITYPE_UNINF_JUMP       = 4'd6;
  localparam logic [3:0] ITYPE_RESERVED         = 4'd7;
  localparam logic [3:0] ITYPE_UNINF_CALL       = 4'd8;
  localparam logic [3:0] ITYPE_INF_CALL         = 4'd9;
  localparam logic [3:0] ITYPE_UNINF_TAIL       = 4'd10;
  localparam logic [3:0] ITYPE_INF_TAIL         = 4'd11;
  localparam logic [3:0] ITYPE_COSWAP           = 4'd12;
  localparam logic [3:0] ITYPE_RETURN           = 4'd13;
  localparam logic [3:0] ITYPE_OTHER_UNINF_JUMP = 4'd14;
  localparam logic [3:0] ITYPE_OTHER_INF_JUMP   = 4'd15;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == LINK_X1) || (idx == LINK_X5);
  endfunction

endpackage

// File: rtl/itype_lane_classify.sv
// Combinational itype classifier for one commit lane.
module itype_lane_classify
  import mure_pkg::*;
#(
  parameter int unsigned ITYPE_LEN = 3
) (
  input  logic                 valid,
  input  logic                 exc,
  input  logic                 intr,
  input  fu_op                 op,
  input  logic                 taken,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  output logic [ITYPE_LEN-1:0] itype
);

  logic rd_link;
  logic rs1_link;
  logic rd_zero;
  logic [ITYPE_LEN-1:0] code;

  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);
  assign rd_zero  = (rd == 5'd0);

  always_comb begin
    code = ITYPE_NONE[ITYPE_LEN-1:0];
    if (exc) begin
      code = ITYPE_EXCEPTION[ITYPE_LEN-1:0];
    end else if (intr) begin
      code = ITYPE_INTERRUPT[ITYPE_LEN-1:0];
    end else if (valid) begin
      case (op)
        MRET, SRET, DRET: code = ITYPE_ERET[ITYPE_LEN-1:0];
        EQ, NE, LTS, GES, LTU, GEU: begin
          code = taken ? ITYPE_TAKEN_BRANCH[ITYPE_LEN-1:0]
                       : ITYPE_NONTAKEN_BRANCH[ITYPE_LEN-1:0];
        end
        // Direct jumps are only reported in the wide encoding.
        JAL: begin
          if (ITYPE_LEN == 4) begin
            if (rd_link)      code = ITYPE_INF_CALL[ITYPE_LEN-1:0];
            else if (rd_zero) code = ITYPE_INF_TAIL[ITYPE_LEN-1:0];
            else              code = ITYPE_OTHER_INF_JUMP[ITYPE_LEN-1:0];
          end
        end
        JALR: begin
          if (ITYPE_LEN == 3) begin
            code = ITYPE_UNINF_JUMP[ITYPE_LEN-1:0];
          end else if (rd_link && rs1_link && (rd != rs1)) begin
            code = ITYPE_COSWAP[ITYPE_LEN-1:0];
          end else if (rd_link) begin
            code = ITYPE_UNINF_CALL[ITYPE_LEN-1:0];
          end else if (rs1_link && rd_zero) begin
            code = ITYPE_RETURN[ITYPE_LEN-1:0];
          end else if (rd_zero) begin
            code = ITYPE_UNINF_TAIL[ITYPE_LEN-1:0];
          end else begin
            code = ITYPE_OTHER_UNINF_JUMP[ITYPE_LEN-1:0];
          end
        end
        default: code = ITYPE_NONE[ITYPE_LEN-1:0];
      endcase
    end
  end

  assign itype = code;

endmodule

// File: rtl/itype_detector_mp.sv
// Multi-lane itype detector with a small output FIFO; back-pressure drops entries, never stalls.
module itype_detector_mp
  import mure_pkg::*;
#(
  parameter int unsigned NRET      = 2,
  parameter int unsigned ITYPE_LEN = 3,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRET-1:0]                valid_i,
  input  logic                           exception_i,
  input  logic                           interrupt_i,
  input  fu_op [NRET-1:0]                op_i,
  input  logic [NRET-1:0]                branch_taken_i,
  input  logic [NRET-1:0][4:0]           rd_i,
  input  logic [NRET-1:0][4:0]           rs1_i,
  input  logic                           ready_i,
  input  logic                           clear_i,
  output logic                           valid_o,
  output logic [NRET-1:0]                lane_valid_o,
  output logic [NRET-1:0][ITYPE_LEN-1:0] itype_o,
  output logic                           overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (ITYPE_LEN != 3 && ITYPE_LEN != 4) begin : g_bad_itype_len
    $error("itype_detector_mp: ITYPE_LEN must be 3 or 4");
  end
  if (NRET < 1 || NRET > 4) begin : g_bad_nret
    $error("itype_detector_mp: NRET must be 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("itype_detector_mp: DEPTH must be a power of two >= 2");
  end

  logic                           trap;
  logic [NRET-1:0]                lane_valid;
  logic [NRET-1:0][ITYPE_LEN-1:0] lane_itype;

  assign trap = exception_i | interrupt_i;

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    // A trap on lane 0 squashes everything retiring alongside it.
    if (i == 0) begin : g_lane0
      assign lane_valid[i] = valid_i[i];
    end else begin : g_laneN
      assign lane_valid[i] = valid_i[i] & ~trap;
    end

    itype_lane_classify #(
      .ITYPE_LEN(ITYPE_LEN)
    ) u_classify (
      .valid(lane_valid[i]),
      .exc  ((i == 0) ? exception_i : 1'b0),
      .intr ((i == 0) ? interrupt_i : 1'b0),
      .op   (op_i[i]),
      .taken(branch_taken_i[i]),
      .rd   (rd_i[i]),
      .rs1  (rs1_i[i]),
      .itype(lane_itype[i])
    );
  end

  logic [AW:0]                    wr_ptr_q;
  logic [AW:0]                    rd_ptr_q;
  logic                           overflow_q;
  logic [NRET-1:0]                mem_valid [DEPTH];
  logic [NRET-1:0][ITYPE_LEN-1:0] mem_itype [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push  = (|valid_i) | trap;
  assign pop   = ~empty & ready_i;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      // A fresh drop wins over a simultaneous clear.
      if (drop)         overflow_q <= 1'b1;
      else if (clear_i) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_valid[wr_ptr_q[AW-1:0]] <= lane_valid;
      mem_itype[wr_ptr_q[AW-1:0]] <= lane_itype;
    end
  end

  assign valid_o      = ~empty;
  assign lane_valid_o = empty ? '0 : mem_valid[rd_ptr_q[AW-1:0]];
  assign itype_o      = empty ? '0 : mem_itype[rd_ptr_q[AW-1:0]];
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_itype_detector_mp.sv
// Directed bench: 2-lane 3-bit instance for FIFO behaviour, 1-lane 4-bit instance for jump codes.
module tb_itype_detector_mp;
  import mure_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  // Instance A: NRET=2, ITYPE_LEN=3, DEPTH=4
  logic [1:0]      a_valid;
  logic            a_exc;
  logic            a_intr;
  fu_op [1:0]      a_op;
  logic [1:0]      a_taken;
  logic [1:0][4:0] a_rd;
  logic [1:0][4:0] a_rs1;
  logic            a_ready;
  logic            a_clear;
  logic            a_valid_o;
  logic [1:0]      a_lane_valid_o;
  logic [1:0][2:0] a_itype_o;
  logic            a_overflow_o;

  // Instance B: NRET=1, ITYPE_LEN=4, DEPTH=4
  logic            b_valid;
  logic            b_exc;
  logic            b_intr;
  fu_op [0:0]      b_op;
  logic            b_taken;
  logic [0:0][4:0] b_rd;
  logic [0:0][4:0] b_rs1;
  logic            b_ready;
  logic            b_clear;
  logic            b_valid_o;
  logic            b_lane_valid_o;
  logic [0:0][3:0] b_itype_o;
  logic            b_overflow_o;

  itype_detector_mp #(.NRET(2), .ITYPE_LEN(3), .DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .exception_i(a_exc), .interrupt_i(a_intr),
    .op_i(a_op), .branch_taken_i(a_taken), .rd_i(a_rd), .rs1_i(a_rs1), .ready_i(a_ready),
    .clear_i(a_clear), .valid_o(a_valid_o), .lane_valid_o(a_lane_valid_o),
    .itype_o(a_itype_o), .overflow_o(a_overflow_o)
  );

  itype_detector_mp #(.NRET(1), .ITYPE_LEN(4), .DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .exception_i(b_exc), .interrupt_i(b_intr),
    .op_i(b_op), .branch_taken_i(b_taken), .rd_i(b_rd), .rs1_i(b_rs1), .ready_i(b_ready),
    .clear_i(b_clear), .valid_o(b_valid_o), .lane_valid_o(b_lane_valid_o),
    .itype_o(b_itype_o), .overflow_o(b_overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_push(input logic [1:0] v, input fu_op o1, input fu_op o0,
                        input logic [1:0] tk);
    a_valid  = v;
    a_op[1]  = o1;
    a_op[0]  = o0;
    a_taken  = tk;
    tick();
  endtask

  task automatic a_idle();
    a_valid = 2'b00;
    a_exc   = 1'b0;
    a_intr  = 1'b0;
    a_taken = 2'b00;
    a_op[0] = ADD;
    a_op[1] = ADD;
  endtask

  task automatic a_head(input string tag, input logic [1:0] lv, input logic [5:0] it);
    check({tag, ".valid"}, 32'(a_valid_o), 32'd1);
    check({tag, ".lane_valid"}, 32'(a_lane_valid_o), 32'(lv));
    check({tag, ".itype"}, 32'(a_itype_o), 32'(it));
  endtask

  task automatic b_vec(input string tag, input fu_op op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic tk, input logic [3:0] exp);
    b_valid  = 1'b1;
    b_op[0]  = op;
    b_rd[0]  = rd;
    b_rs1[0] = rs1;
    b_taken  = tk;
    tick();
    check({tag, ".valid"}, 32'(b_valid_o), 32'd1);
    check({tag, ".itype"}, 32'(b_itype_o), 32'(exp));
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    a_idle();
    a_rd    = '0;
    a_rs1   = '0;
    a_ready = 1'b1;
    a_clear = 1'b0;
    b_valid = 1'b0;
    b_exc   = 1'b0;
    b_intr  = 1'b0;
    b_op[0] = ADD;
    b_taken = 1'b0;
    b_rd    = '0;
    b_rs1   = '0;
    b_ready = 1'b1;
    b_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset.valid", 32'(a_valid_o), 32'd0);
    check("reset.lane_valid", 32'(a_lane_valid_o), 32'd0);
    check("reset.itype", 32'(a_itype_o), 32'd0);
    check("reset.overflow", 32'(a_overflow_o), 32'd0);
    check("reset.b_valid", 32'(b_valid_o), 32'd0);

    // Lane0 taken BEQ, lane1 JALR: {6,5}
    a_push(2'b11, JALR, EQ, 2'b01);
    a_idle();
    a_head("beq_jalr", 2'b11, {3'd6, 3'd5});
    tick();
    check("beq_jalr.drained", 32'(a_valid_o), 32'd0);

    a_push(2'b11, MRET, NE, 2'b00);
    a_idle();
    a_head("ne_mret", 2'b11, {3'd3, 3'd4});

    // JAL is not reported in the 3-bit encoding
    a_push(2'b11, JAL, ADD, 2'b00);
    a_idle();
    a_head("add_jal", 2'b11, {3'd0, 3'd0});

    a_intr = 1'b1;
    a_push(2'b00, ADD, ADD, 2'b00);
    a_idle();
    a_head("intr", 2'b00, {3'd0, 3'd2});

    // Exception wins over interrupt; lane1 squashed
    a_exc  = 1'b1;
    a_intr = 1'b1;
    a_push(2'b11, MRET, ADD, 2'b00);
    a_idle();
    a_head("exc_intr", 2'b01, {3'd0, 3'd1});
    tick();
    check("exc_intr.drained", 32'(a_valid_o), 32'd0);

    // Fill, then push and pop in the same cycle: no drop
    a_ready = 1'b0;
    a_push(2'b01, ADD, SRET, 2'b00);
    a_push(2'b01, ADD, GEU, 2'b01);
    a_push(2'b01, ADD, LTU, 2'b00);
    a_push(2'b01, ADD, JALR, 2'b00);
    a_head("full.head", 2'b01, 6'd3);
    a_ready = 1'b1;
    a_push(2'b11, EQ, JALR, 2'b10);
    a_idle();
    check("pushpop.overflow", 32'(a_overflow_o), 32'd0);
    a_head("pushpop.e2", 2'b01, 6'd5);
    tick();
    a_head("pushpop.e3", 2'b01, 6'd4);
    tick();
    a_head("pushpop.e4", 2'b01, 6'd6);
    tick();
    a_head("pushpop.e5", 2'b11, {3'd5, 3'd6});
    tick();
    check("pushpop.empty", 32'(a_valid_o), 32'd0);
    check("pushpop.empty_itype", 32'(a_itype_o), 32'd0);

    // Five pushes into a stalled FIFO: fifth dropped
    a_ready = 1'b0;
    a_push(2'b01, ADD, EQ, 2'b01);
    a_push(2'b01, ADD, NE, 2'b00);
    a_push(2'b01, ADD, MRET, 2'b00);
    a_push(2'b01, ADD, JALR, 2'b00);
    check("ovf.before_drop", 32'(a_overflow_o), 32'd0);
    a_push(2'b01, ADD, ADD, 2'b00);
    a_idle();
    check("ovf.after_drop", 32'(a_overflow_o), 32'd1);
    a_head("ovf.stable_head", 2'b01, 6'd5);
    a_ready = 1'b1;
    tick();
    a_head("ovf.e2", 2'b01, 6'd4);
    tick();
    a_head("ovf.e3", 2'b01, 6'd3);
    tick();
    a_head("ovf.e4", 2'b01, 6'd6);
    tick();
    check("ovf.drained", 32'(a_valid_o), 32'd0);
    check("ovf.sticky", 32'(a_overflow_o), 32'd1);

    // Reset with three entries queued and overflow set
    a_ready = 1'b0;
    a_push(2'b01, ADD, ADD, 2'b00);
    a_push(2'b01, ADD, ADD, 2'b00);
    a_push(2'b01, ADD, EQ, 2'b01);
    a_idle();
    a_head("prerst", 2'b01, 6'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.valid", 32'(a_valid_o), 32'd0);
    check("rst.overflow", 32'(a_overflow_o), 32'd0);
    check("rst.lane_valid", 32'(a_lane_valid_o), 32'd0);
    tick();
    check("rst.still_empty", 32'(a_valid_o), 32'd0);

    // Clear coinciding with a drop keeps overflow set
    a_push(2'b01, ADD, ADD, 2'b00);
    a_push(2'b01, ADD, ADD, 2'b00);
    a_push(2'b01, ADD, ADD, 2'b00);
    a_push(2'b01, ADD, ADD, 2'b00);
    a_clear = 1'b1;
    a_push(2'b01, ADD, ADD, 2'b00);
    a_idle();
    check("clear_drop.overflow", 32'(a_overflow_o), 32'd1);
    tick();
    a_clear = 1'b0;
    check("clear.overflow", 32'(a_overflow_o), 32'd0);
    check("clear.valid", 32'(a_valid_o), 32'd1);

    // 4-bit encoding, one lane, back-to-back with ready high
    b_vec("coswap", JALR, 5'd1, 5'd5, 1'b0, 4'd12);
    b_vec("return", JALR, 5'd0, 5'd1, 1'b0, 4'd13);
    b_vec("jal_call", JAL, 5'd5, 5'd0, 1'b0, 4'd9);
    b_vec("jalr_same_link", JALR, 5'd1, 5'd1, 1'b0, 4'd8);
    b_vec("jal_tail", JAL, 5'd0, 5'd0, 1'b0, 4'd11);
    b_vec("jal_other", JAL, 5'd3, 5'd0, 1'b0, 4'd15);
    b_vec("jalr_tail", JALR, 5'd0, 5'd3, 1'b0, 4'd10);
    b_vec("jalr_other", JALR, 5'd3, 5'd3, 1'b0, 4'd14);
    b_vec("jalr_rs1link_rd3", JALR, 5'd3, 5'd1, 1'b0, 4'd14);
    b_vec("jalr_call_x5", JALR, 5'd5, 5'd2, 1'b0, 4'd8);
    b_vec("b_eret", SRET, 5'd0, 5'd0, 1'b0, 4'd3);
    b_vec("b_br_taken", LTS, 5'd0, 5'd0, 1'b1, 4'd5);
    b_valid = 1'b0;
    b_intr  = 1'b1;
    tick();
    b_intr  = 1'b0;
    check("b_intr.itype", 32'(b_itype_o), 32'd2);
    check("b_intr.lane_valid", 32'(b_lane_valid_o), 32'd0);
    tick();
    check("b_drained", 32'(b_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/itype_detector_mp.md
# itype_detector_mp

Multi-retire, buffered instruction-type detector for the trace encoder path. Each cycle it classifies up to NRET committed instructions into E-Trace itype codes in 3-bit or 4-bit mode. The 4-bit mode adds call/return/jump discrimination from rd/rs1. Results are queued in a small FIFO and handed to the encoder through a valid/ready handshake, so encoder back-pressure never stalls commit; drops are flagged.

## Interface
Parameters:
- NRET, 2: commit lanes, 1..4.
- ITYPE_LEN, 3: itype width; 3 or 4. Any other value is an elaboration error.
- DEPTH, 4: FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous and active-high.
- valid_i  in  NRET  per-lane instruction committed.
- exception_i  in  1  exception on lane 0.
- interrupt_i  in  1  interrupt; no committed instruction needed.
- op_i  in  NRET×mure_pkg::fu_op  per-lane functional-unit op.
- branch_taken_i  in  NRET  per-lane branch outcome.
- rd_i  in  NRET×5  per-lane destination register index.
- rs1_i  in  NRET×5  per-lane source-1 register index.
- ready_i  in  1  encoder accepts head entry.
- clear_i  in  1  clears overflow_o.
- valid_o  out  1  head entry available.
- lane_valid_o  out  NRET  head entry per-lane valid.
- itype_o  out  NRET×ITYPE_LEN  head entry per-lane itype.
- overflow_o  out  1  sticky: an entry was dropped.

## Operation
Lane classification, highest priority first:
- Lane 0 only: exception_i → 1; else interrupt_i → 2.
- When exception_i or interrupt_i is set, lanes ≥1 are forced to valid 0, itype 0.
- MRET/SRET/DRET → 3.
- EQ/NE/LTS/GES/LTU/GEU → 4 if not taken, 5 if taken.
- ITYPE_LEN=3: JALR → 6.
- ITYPE_LEN=4, link register = x1 or x5:
  - JAL: rd link → 9; rd=x0 → 11; else 15.
  - JALR: rd and rs1 both link with rd≠rs1 → 12; rd link → 8; rs1 link and rd=x0 → 13; rd=x0 → 10; else 14.
- Valid lane with none of the above → 0.
- Types 3–15 require the lane's valid_i. Types 1/2 do not.

FIFO:
- Push when any valid_i, exception_i or interrupt_i is set. The entry is {lane_valid, itype per lane}.
- Pop when valid_o && ready_i.
- Push while full with no pop: entry dropped, overflow_o=1.
- Push while full with pop: both occur; no drop.
- Empty: valid_o=0; lane_valid_o and itype_o driven 0.
- overflow_o holds until clear_i. If clear_i and a drop occur in the same cycle, overflow_o stays 1.
- Pointers are log2(DEPTH) bits plus one wrap bit. full = indices equal and wrap bits differ.

## Timing
- Reset values: valid_o=0, lane_valid_o=0, itype_o=0, overflow_o=0, pointers=0.
- Reset mid-operation discards all entries in the next cycle.
- Latency: input sampled at edge N is visible on outputs after edge N, i.e. in cycle N+1, when the FIFO is empty.
- Throughput: one entry per cycle in and out.
- ready_i has no combinational path to any input-side logic other than the full/drop decision.
- Head outputs are stable while valid_o && !ready_i.
- No combinational path from any input to any output.

## Structure
- mure_pkg gains:
  - ITYPE codes as localparams: ITYPE_NONE..ITYPE_OTHER_INF_JUMP, 0..15.
  - LINK_X1=5'd1 and LINK_X5=5'd5.
  - Function is_link(reg).
- Sub-module itype_lane_classify: combinational, one per lane, generate loop. Inputs: valid, exc, intr, op, taken, rd, rs1. Output: itype. Parameter: ITYPE_LEN.
- FIFO storage is a flat array inside itype_detector_mp; no generic FIFO instance.

## Test plan
- NRET=2, ITYPE_LEN=3, ready_i=1. Lane0 BEQ taken, lane1 JALR. → Next cycle: valid_o=1, itype_o={6,5}, lane_valid_o=2'b11.
- interrupt_i=1 with valid_i=0. → One entry: lane_valid_o=0, lane0 itype 2, lane1 itype 0. exception_i+interrupt_i together → lane0 itype 1.
- ITYPE_LEN=4, single lane:
  - JALR rd=x1, rs1=x5 → 12.
  - JALR rd=x0, rs1=x1 → 13.
  - JAL rd=x5 → 9.
  - JALR rd=x1, rs1=x1 → 8.
- DEPTH=4, ready_i=0, 5 consecutive pushes. → First 4 retained, 5th dropped, overflow_o=1 from the next cycle. Releasing ready_i drains the 4 entries in order.
- Full FIFO, push and pop in the same cycle. → No drop, overflow_o stays 0, count unchanged.
- rst_i asserted with 3 entries queued. → Next cycle valid_o=0, overflow_o=0. clear_i together with a drop → overflow_o=1.
